// File: rtl/joybus_pkg.sv
// Shared Joybus definitions: command codes, FSM state encoding and wire-slot quarter counts.
package joybus_pkg;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_RESET  = 8'hFF;

  localparam int QUARTERS_ZERO_LOW = 3;
  localparam int QUARTERS_ONE_LOW  = 1;
  localparam int QUARTERS_SLOT     = 4;
  localparam int STOP_LOW          = 2;
  localparam int STOP_SLOT         = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_CMD,
    ST_RX_STOP,
    ST_TURNAROUND,
    ST_TX_BITS,
    ST_TX_STOP,
    ST_IGNORE
  } state_t;

  function automatic logic cmd_answered(input logic [7:0] code);
    return (code == CMD_INFO) || (code == CMD_STATUS) || (code == CMD_RESET);
  endfunction

endpackage

// File: rtl/joybus_bit_tx.sv
// Drives one Joybus wire slot (data bit or stop) on a start strobe; done pulses on the slot's
// final cycle so the next start can follow back-to-back without a gap.
module joybus_bit_tx
  import joybus_pkg::*;
#(
  parameter int CLKS_PER_US = 4
) (
  input  logic sample_clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  input  logic stop_mode,
  output logic oe,
  output logic done
);

  localparam int CW = $clog2(QUARTERS_SLOT * CLKS_PER_US + 1);
  localparam logic [CW-1:0] LOW_ZERO  = CW'(QUARTERS_ZERO_LOW * CLKS_PER_US);
  localparam logic [CW-1:0] LOW_ONE   = CW'(QUARTERS_ONE_LOW * CLKS_PER_US);
  localparam logic [CW-1:0] LOW_STOP  = CW'(STOP_LOW * CLKS_PER_US);
  localparam logic [CW-1:0] SLOT_BIT  = CW'(QUARTERS_SLOT * CLKS_PER_US);
  localparam logic [CW-1:0] SLOT_STOP = CW'(STOP_SLOT * CLKS_PER_US);

  logic          active;
  logic [CW-1:0] cnt;
  logic [CW-1:0] low_len;
  logic [CW-1:0] slot_len;

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      active   <= 1'b0;
      cnt      <= '0;
      low_len  <= '0;
      slot_len <= '0;
      oe       <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        cnt      <= CW'(1);
        oe       <= 1'b1;
        low_len  <= stop_mode ? LOW_STOP : (bit_val ? LOW_ONE : LOW_ZERO);
        slot_len <= stop_mode ? SLOT_STOP : SLOT_BIT;
      end else if (active) begin
        cnt <= cnt + 1'b1;
        if (cnt == low_len) oe <= 1'b0;
        // done lands on the last slot cycle so a same-cycle restart keeps the period exact
        if (cnt == slot_len - 1'b1) begin
          done   <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/joybus_device.sv
// N64 Joybus device endpoint: RX oversampling, command decode, INFO/RESET/STATUS responses.
// Optional JOYBUS_RX_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchroniser.
module joybus_device
  import joybus_pkg::*;
#(
  parameter int          CLKS_PER_US   = 4,
  parameter logic [15:0] DEVICE_ID     = 16'h0500,
  parameter logic [7:0]  PAK_STATUS    = 8'h02,
  parameter int          RESP_DELAY_US = 2,
  parameter int          TIMEOUT_US    = 12
) (
  input  logic        sample_clk,
  input  logic        reset,
  input  logic        data_rx,
  output logic        data_tx_oe,
  input  logic [15:0] buttons,
  input  logic [7:0]  stick_x,
  input  logic [7:0]  stick_y,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        reset_cmd,
  output logic        busy,
  output logic        rx_err,
  output state_t      state
);

  localparam int TW = $clog2(TIMEOUT_US * CLKS_PER_US + 1);
  localparam logic [TW-1:0] T_SAMPLE  = TW'(2 * CLKS_PER_US);
  localparam logic [TW-1:0] T_BIT     = TW'(4 * CLKS_PER_US);
  localparam logic [TW-1:0] T_RESP    = TW'(RESP_DELAY_US * CLKS_PER_US);
  localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_US * CLKS_PER_US);

  logic rx_s1, rx_s2, line, line_d, fall;

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= data_rx;
      rx_s2 <= rx_s1;
    end
  end

`ifdef JOYBUS_RX_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       line_f;
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      hist   <= 2'b11;
      line_f <= 1'b1;
    end else begin
      hist   <= {hist[0], rx_s2};
      line_f <= (rx_s2 & hist[0]) | (rx_s2 & hist[1]) | (hist[0] & hist[1]);
    end
  end
  assign line = line_f;
`else
  assign line = rx_s2;
`endif

  assign fall = line_d & ~line;

  // cnt: cycles since the last falling edge (reused as high-cycle count in TURNAROUND)
  // hcnt: length of the current continuous high run; both saturate
  logic [TW-1:0] cnt, hcnt;
  logic          rose;
  logic [6:0]    rx_sh;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_byte;
  logic [31:0]   tx_sh;
  logic [5:0]    bits_left;
  logic          tx_start, tx_stop, tx_done;

  assign rx_byte  = {rx_sh, line};
  assign tx_stop  = (bits_left == '0);
  assign tx_start = ((state == ST_TURNAROUND) && (cnt == T_RESP)) ||
                    ((state == ST_TX_BITS) && tx_done);

  always_ff @(posedge sample_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      line_d    <= 1'b1;
      cnt       <= '0;
      hcnt      <= '0;
      rose      <= 1'b0;
      rx_sh     <= '0;
      rx_bits   <= '0;
      tx_sh     <= '0;
      bits_left <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'hFE;
      reset_cmd <= 1'b0;
      busy      <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      line_d    <= line;
      cmd_valid <= 1'b0;
      reset_cmd <= 1'b0;
      rx_err    <= 1'b0;
      hcnt      <= line ? ((hcnt == T_TIMEOUT) ? hcnt : hcnt + 1'b1) : '0;
      if (fall) begin
        cnt  <= TW'(1);
        rose <= 1'b0;
      end else begin
        if (cnt != T_TIMEOUT) cnt <= cnt + 1'b1;
        if (line) rose <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state   <= ST_RX_CMD;
            busy    <= 1'b1;
            rx_bits <= '0;
          end
        end
        ST_RX_CMD, ST_RX_STOP: begin
          if (hcnt == T_TIMEOUT) begin
            rx_err <= 1'b1;
            state  <= ST_IDLE;
            busy   <= 1'b0;
          end else if ((cnt == T_BIT) && !rose) begin
            rx_err <= 1'b1;
            state  <= ST_IGNORE;
          end else if ((cnt == T_SAMPLE) && !fall) begin
            if (state == ST_RX_CMD) begin
              rx_sh   <= rx_byte[6:0];
              rx_bits <= rx_bits + 1'b1;
              if (rx_bits == 3'd7) begin
                cmd_valid <= 1'b1;
                cmd_code  <= rx_byte;
                reset_cmd <= (rx_byte == CMD_RESET);
                state     <= cmd_answered(rx_byte) ? ST_RX_STOP : ST_IGNORE;
              end
            end else if (line) begin
              // console stop seen: freeze the response for this frame
              if (cmd_code == CMD_STATUS) begin
                tx_sh     <= {buttons, stick_x, stick_y};
                bits_left <= 6'd32;
              end else begin
                tx_sh     <= {DEVICE_ID, PAK_STATUS, 8'h00};
                bits_left <= 6'd24;
              end
              cnt   <= '0;
              state <= ST_TURNAROUND;
            end else begin
              state <= ST_IGNORE;
            end
          end
        end
        ST_TURNAROUND: begin
          if (tx_start) begin
            state     <= ST_TX_BITS;
            tx_sh     <= {tx_sh[30:0], 1'b0};
            bits_left <= bits_left - 1'b1;
          end else begin
            cnt <= line ? cnt + 1'b1 : cnt;
          end
        end
        ST_TX_BITS: begin
          if (tx_start) begin
            if (tx_stop) begin
              state <= ST_TX_STOP;
            end else begin
              tx_sh     <= {tx_sh[30:0], 1'b0};
              bits_left <= bits_left - 1'b1;
            end
          end
        end
        ST_TX_STOP: begin
          if (tx_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IGNORE: begin
          if (hcnt == T_TIMEOUT) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  joybus_bit_tx #(.CLKS_PER_US(CLKS_PER_US)) u_bit_tx (
    .sample_clk (sample_clk),
    .reset      (reset),
    .start      (tx_start),
    .bit_val    (tx_sh[31]),
    .stop_mode  (tx_stop),
    .oe         (data_tx_oe),
    .done       (tx_done)
  );

endmodule
